// File: rtl/traffic_phase_sched_pkg.sv
// Shared definitions for the intersection controller: lamp codes, phase
// encodings and configuration selector values.
package traffic_pkg;

    localparam logic [5:0] GNS = 6'b100001;
    localparam logic [5:0] YNS = 6'b010001;
    localparam logic [5:0] GEW = 6'b001100;
    localparam logic [5:0] YEW = 6'b001010;

    typedef enum logic [1:0] {
        PH_GNS = 2'd0,
        PH_YNS = 2'd1,
        PH_GEW = 2'd2,
        PH_YEW = 2'd3
    } phase_e;

    // Selector values match phase encodings, so a phase indexes its own duration.
    localparam logic [1:0] CFG_MIN_GNS = 2'd0;
    localparam logic [1:0] CFG_YNS     = 2'd1;
    localparam logic [1:0] CFG_GEW     = 2'd2;
    localparam logic [1:0] CFG_YEW     = 2'd3;

    function automatic logic [5:0] lamp_of(input phase_e ph);
        case (ph)
            PH_GNS:  return GNS;
            PH_YNS:  return YNS;
            PH_GEW:  return GEW;
            default: return YEW;
        endcase
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_GNS:  return PH_YNS;
            PH_YNS:  return PH_GEW;
            PH_GEW:  return PH_YEW;
            default: return PH_GNS;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_sched_timer.sv
// Per-phase dwell counter: captures the duration on load, counts ticks and
// saturates at D-1 so a held phase never wraps.
module phase_timer #(
    parameter int CNT_W   = 8,
    parameter int RST_DUR = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] dur,
    output logic             expired,
    output logic             sat
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last;

    // Terminal count is D-1, with a zero duration behaving as one tick.
    function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    assign sat     = (r_cnt == r_last);
    assign expired = tick & sat;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_last <= last_of(CNT_W'(RST_DUR));
        end else if (load) begin
            r_cnt  <= '0;
            r_last <= last_of(dur);
        end else if (tick && !sat) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road intersection phase sequencer: GNS -> YNS -> GEW -> YEW with
// programmable dwell times, latched EW requests and a minimum NS green.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEF_MIN_GNS = 10,
    parameter int DEF_YNS     = 3,
    parameter int DEF_GEW     = 8,
    parameter int DEF_YEW     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             carew,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_val,
    output logic [5:0]       LightOut,
    output logic [1:0]       phase,
    output logic             phase_start,
    output logic             req_pending
);

    phase_e           r_phase;
    logic [5:0]       r_light;
    logic             r_start;
    logic             r_req;
    logic [CNT_W-1:0] r_cfg_min_gns;
    logic [CNT_W-1:0] r_cfg_yns;
    logic [CNT_W-1:0] r_cfg_gew;
    logic [CNT_W-1:0] r_cfg_yew;

    phase_e           w_next;
    logic [CNT_W-1:0] w_next_dur;
    logic             w_expired;
    logic             w_sat;
    logic             w_adv;
    logic             w_enter_yns;

    assign w_next = next_phase(r_phase);

    always_comb begin
        w_next_dur = r_cfg_min_gns;
        case (w_next)
            PH_GNS:  w_next_dur = r_cfg_min_gns;
            PH_YNS:  w_next_dur = r_cfg_yns;
            PH_GEW:  w_next_dur = r_cfg_gew;
            default: w_next_dur = r_cfg_yew;
        endcase
    end

    // GNS leaves only once min-green is done (saturated) and a request is held.
    assign w_adv       = (r_phase == PH_GNS) ? (tick & w_sat & r_req) : w_expired;
    assign w_enter_yns = w_adv & (r_phase == PH_GNS);

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_DUR (DEF_MIN_GNS)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .tick    (tick),
        .load    (w_adv),
        .dur     (w_next_dur),
        .expired (w_expired),
        .sat     (w_sat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= PH_GNS;
            r_light <= GNS;
            r_start <= 1'b0;
        end else begin
            r_start <= w_adv;
            if (w_adv) begin
                r_phase <= w_next;
                r_light <= lamp_of(w_next);
            end
        end
    end

    // A new request on the YNS entry edge outranks the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req <= 1'b0;
        end else if (carew) begin
            r_req <= 1'b1;
        end else if (w_enter_yns) begin
            r_req <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfg_min_gns <= CNT_W'(DEF_MIN_GNS);
            r_cfg_yns     <= CNT_W'(DEF_YNS);
            r_cfg_gew     <= CNT_W'(DEF_GEW);
            r_cfg_yew     <= CNT_W'(DEF_YEW);
        end else if (cfg_we) begin
            case (cfg_sel)
                CFG_MIN_GNS: r_cfg_min_gns <= cfg_val;
                CFG_YNS:     r_cfg_yns     <= cfg_val;
                CFG_GEW:     r_cfg_gew     <= cfg_val;
                default:     r_cfg_yew     <= cfg_val;
            endcase
        end
    end

    assign LightOut    = r_light;
    assign phase       = r_phase;
    assign phase_start = r_start;
    assign req_pending = r_req;

endmodule
